// File: rtl/patch_pkg.sv
// Shared definitions for the patch control unit: FSM states, register map
// addresses and CTRL register bit positions.
package patch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    FIRING = 2'd2,
    DONE   = 2'd3
  } patch_state_e;

  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_TRIG_MASK = 3'd1;
  localparam logic [2:0] ADDR_TRIG_VAL  = 3'd2;
  localparam logic [2:0] ADDR_OVR_MASK  = 3'd3;
  localparam logic [2:0] ADDR_OVR_VAL   = 3'd4;
  localparam logic [2:0] ADDR_HOLD      = 3'd5;

  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_ONESHOT_BIT = 1;

endpackage

// File: rtl/patch_control_unit_if.sv
// Patch configuration bus.
// Handshake: a write is transferred on every rising edge where cfg_valid and
// cfg_ready are both high; cfg_ready is held high, so every strobe is taken.
// cfg_err is a one-cycle pulse, in the cycle after the transfer, for a write
// that was rejected (bad address, or data register while enabled).
interface patch_control_unit_if #(parameter int CFG_W = 16);
  logic             cfg_valid;
  logic [2:0]       cfg_addr;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_addr, cfg_data, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_addr, cfg_data, output cfg_ready, cfg_err);
endinterface

// File: rtl/patch_trigger_match.sv
// Masked trigger compare: match when every masked observe bit equals the
// programmed trigger value. A zero mask matches unconditionally.
module patch_trigger_match #(
  parameter int OBS_W = 3
) (
  input  logic [OBS_W-1:0] observe,
  input  logic [OBS_W-1:0] trig_mask,
  input  logic [OBS_W-1:0] trig_val,
  output logic             match
);

  assign match = ((observe ^ trig_val) & trig_mask) == '0;

endmodule

// File: rtl/patch_control_unit.sv
// Patch control unit: passes control signals through until a programmed
// trigger fires, then overrides selected bits for HOLD+1 cycles.
// Optional build macro PATCH_EVENT_CNT_EN adds a saturating event_count port.
module patch_control_unit
  import patch_pkg::*;
#(
  parameter int OBS_W  = 3,
  parameter int CTRL_W = 6,
  parameter int CNT_W  = 8,
  parameter int CFG_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OBS_W-1:0]      observe_port,
  input  logic [CTRL_W-1:0]     control_port_in,
  output logic [CTRL_W-1:0]     control_port_out,
  patch_control_unit_if.slave   cfg,
  output logic                  patch_active,
`ifdef PATCH_EVENT_CNT_EN
  output logic [CNT_W-1:0]      event_count,
`endif
  output patch_state_e          dbg_state
);

  logic [1:0]        ctrl_q, ctrl_d;
  logic [OBS_W-1:0]  trig_mask_q, trig_mask_d, trig_val_q, trig_val_d;
  logic [CTRL_W-1:0] ovr_mask_q, ovr_mask_d, ovr_val_q, ovr_val_d;
  logic [CNT_W-1:0]  hold_q, hold_d, cnt_q, cnt_d;
  patch_state_e      state_q, state_d;
  logic              cfg_err_q, cfg_err_d;
  logic              wr_en, cfg_locked, ctrl_wr_en1, ctrl_wr_dis, match, fire;
  logic              cfg_unused;

  assign wr_en       = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg_locked  = ctrl_q[CTRL_ENABLE_BIT];
  assign ctrl_wr_en1 = wr_en && (cfg.cfg_addr == ADDR_CTRL) && cfg.cfg_data[CTRL_ENABLE_BIT];
  assign ctrl_wr_dis = wr_en && (cfg.cfg_addr == ADDR_CTRL) && !cfg.cfg_data[CTRL_ENABLE_BIT];
  // Upper data bits beyond each register width are don't-care.
  assign cfg_unused  = ^cfg.cfg_data;

  patch_trigger_match #(.OBS_W(OBS_W)) u_match (
    .observe   (observe_port),
    .trig_mask (trig_mask_q),
    .trig_val  (trig_val_q),
    .match     (match)
  );

  // Register file writes; data registers are frozen while enabled.
  always_comb begin
    ctrl_d      = ctrl_q;
    trig_mask_d = trig_mask_q;
    trig_val_d  = trig_val_q;
    ovr_mask_d  = ovr_mask_q;
    ovr_val_d   = ovr_val_q;
    hold_d      = hold_q;
    cfg_err_d   = 1'b0;
    if (wr_en) begin
      case (cfg.cfg_addr)
        ADDR_CTRL:      ctrl_d = cfg.cfg_data[1:0];
        ADDR_TRIG_MASK: if (cfg_locked) cfg_err_d = 1'b1; else trig_mask_d = cfg.cfg_data[OBS_W-1:0];
        ADDR_TRIG_VAL:  if (cfg_locked) cfg_err_d = 1'b1; else trig_val_d  = cfg.cfg_data[OBS_W-1:0];
        ADDR_OVR_MASK:  if (cfg_locked) cfg_err_d = 1'b1; else ovr_mask_d  = cfg.cfg_data[CTRL_W-1:0];
        ADDR_OVR_VAL:   if (cfg_locked) cfg_err_d = 1'b1; else ovr_val_d   = cfg.cfg_data[CTRL_W-1:0];
        ADDR_HOLD:      if (cfg_locked) cfg_err_d = 1'b1; else hold_d      = cfg.cfg_data[CNT_W-1:0];
        default:        cfg_err_d = 1'b1;
      endcase
    end
  end

  // FSM next state and hold counter; a disable write wins over everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    case (state_q)
      IDLE:   if (ctrl_q[CTRL_ENABLE_BIT]) state_d = ARMED;
      ARMED:  if (match) begin
                state_d = FIRING;
                cnt_d   = hold_q;
                fire    = 1'b1;
              end
      FIRING: if (cnt_q == '0) state_d = ctrl_q[CTRL_ONESHOT_BIT] ? DONE : ARMED;
              else cnt_d = cnt_q - CNT_W'(1);
      DONE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (ctrl_wr_dis) begin
      state_d = IDLE;
      fire    = 1'b0;
    end
  end

  // State, counter and register flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ctrl_q      <= '0;
      trig_mask_q <= '0;
      trig_val_q  <= '0;
      ovr_mask_q  <= '0;
      ovr_val_q   <= '0;
      hold_q      <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
      trig_mask_q <= trig_mask_d;
      trig_val_q  <= trig_val_d;
      ovr_mask_q  <= ovr_mask_d;
      ovr_val_q   <= ovr_val_d;
      hold_q      <= hold_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign patch_active     = (state_q == FIRING);
  assign control_port_out = patch_active ? ((control_port_in & ~ovr_mask_q) | (ovr_val_q & ovr_mask_q))
                                         : control_port_in;
  assign cfg.cfg_ready    = 1'b1;
  assign cfg.cfg_err      = cfg_err_q;
  assign dbg_state        = state_q;

`ifdef PATCH_EVENT_CNT_EN
  logic [CNT_W-1:0] evt_q, evt_d;

  // Saturating trigger counter, cleared whenever the unit is (re)enabled.
  always_comb begin
    evt_d = evt_q;
    if (ctrl_wr_en1) evt_d = '0;
    else if (fire && (evt_q != '1)) evt_d = evt_q + CNT_W'(1);
  end

  // Event counter flop.
  always_ff @(posedge clk) begin
    if (rst) evt_q <= '0;
    else     evt_q <= evt_d;
  end

  assign event_count = evt_q;
`else
  logic fire_unused;
  assign fire_unused = fire;
`endif

endmodule

// File: tb/tb_patch_control_unit.sv
// Testbench for patch_control_unit: directed scenarios plus randomized
// traffic, checked cycle by cycle against a behavioural model.
module tb_patch_control_unit;
  import patch_pkg::*;

  localparam int CFG_W = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] observe_port;
  logic [5:0] control_port_in, control_port_out;
  logic       patch_active;
  patch_state_e dbg_state;
`ifdef PATCH_EVENT_CNT_EN
  logic [7:0] event_count;
`endif

  always #5 clk = ~clk;

  patch_control_unit_if #(.CFG_W(CFG_W)) cfg_bus ();

  patch_control_unit dut (
    .clk              (clk),
    .rst              (rst),
    .observe_port     (observe_port),
    .control_port_in  (control_port_in),
    .control_port_out (control_port_out),
    .cfg              (cfg_bus),
    .patch_active     (patch_active),
`ifdef PATCH_EVENT_CNT_EN
    .event_count      (event_count),
`endif
    .dbg_state        (dbg_state)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Registers as programmed, plus the override seen as "cycles left to force".
  bit         m_en, m_os, m_armed, m_done, m_err;
  logic [2:0] m_tmask, m_tval;
  logic [5:0] m_omask, m_oval;
  logic [7:0] m_hold;
  int         m_fire_left;
  int         m_events;

  // expected {state[1:0], cfg_err, patch_active} for the cycle after an edge
  logic [3:0] exp_q[$];

  function automatic logic [1:0] model_state();
    if (m_fire_left > 0) return FIRING;
    if (m_armed)         return ARMED;
    if (m_done)          return DONE;
    return IDLE;
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [2:0] a,
                            input logic [15:0] d, input logic [2:0] o);
    bit match, dis, old_en;
    if (r) begin
      m_en = 0; m_os = 0; m_armed = 0; m_done = 0; m_err = 0;
      m_tmask = '0; m_tval = '0; m_omask = '0; m_oval = '0; m_hold = '0;
      m_fire_left = 0; m_events = 0;
    end else begin
      match  = ((o ^ m_tval) & m_tmask) == 3'b000;
      old_en = m_en;
      dis    = v && (a == 3'd0) && !d[0];
      m_err  = 0;
      if (dis) begin
        m_armed = 0; m_done = 0; m_fire_left = 0;
      end else if (m_fire_left > 0) begin
        m_fire_left--;
        if (m_fire_left == 0) begin
          if (m_os) m_done = 1;
          else      m_armed = 1;
        end
      end else if (m_armed) begin
        if (match) begin
          m_armed     = 0;
          m_fire_left = int'(m_hold) + 1;
          if (m_events < 255) m_events++;
        end
      end else if (!m_done && m_en) begin
        m_armed = 1;
      end
      if (v) begin
        if (a == 3'd0) begin
          m_en = d[0];
          m_os = d[1];
          if (d[0]) m_events = 0;
        end else if (a <= 3'd5 && !old_en) begin
          case (a)
            3'd1: m_tmask = d[2:0];
            3'd2: m_tval  = d[2:0];
            3'd3: m_omask = d[5:0];
            3'd4: m_oval  = d[5:0];
            default: m_hold = d[7:0];
          endcase
        end else begin
          m_err = 1;
        end
      end
    end
    exp_q.push_back({model_state(), m_err, m_fire_left > 0});
  endtask

  // ---------------- scoreboard compare ----------------
  logic       s_active, s_err;
  logic [5:0] s_out;
  logic [1:0] s_state;

  task automatic compare(input logic [5:0] ci);
    logic [3:0] e;
    logic [5:0] eo;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      eo = e[0] ? ((ci & ~m_omask) | (m_oval & m_omask)) : ci;
      check("state",     32'(dbg_state),       32'(e[3:2]));
      check("cfg_err",   32'(cfg_bus.cfg_err), 32'(e[1]));
      check("active",    32'(patch_active),    32'(e[0]));
      check("ctrl_out",  32'(control_port_out), 32'(eo));
      check("cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
`ifdef PATCH_EVENT_CNT_EN
      check("event_count", 32'(event_count), 32'(m_events));
`endif
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit r, input bit v, input logic [2:0] a,
                       input logic [15:0] d, input logic [2:0] o, input logic [5:0] ci);
    @(negedge clk);
    rst               = r;
    cfg_bus.cfg_valid = v;
    cfg_bus.cfg_addr  = a;
    cfg_bus.cfg_data  = d;
    observe_port      = o;
    control_port_in   = ci;
    #1;
    compare(ci);
    s_active = patch_active;
    s_err    = cfg_bus.cfg_err;
    s_out    = control_port_out;
    s_state  = dbg_state;
    @(posedge clk);
    model_step(r, v, a, d, o);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cycle(1'b0, 1'b1, a, d, 3'b000, 6'h3F);
  endtask

  task automatic idle(input logic [2:0] o, input logic [5:0] ci);
    cycle(1'b0, 1'b0, 3'd0, 16'h0, o, ci);
  endtask

  task automatic cfg_basic(input logic [7:0] hold);
    wr(3'd1, 16'h0005);
    wr(3'd2, 16'h0004);
    wr(3'd3, 16'h0001);
    wr(3'd4, 16'h0000);
    wr(3'd5, {8'h00, hold});
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int cnt_a, cnt_o, cnt_e;
    logic [15:0] rd;
    rst = 1'b1;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_addr = '0; cfg_bus.cfg_data = '0;
    observe_port = '0; control_port_in = '0;

    // 1: reset and pass-through
    cycle(1'b1, 1'b0, 3'd0, 16'h0, 3'b000, 6'h00);
    cycle(1'b1, 1'b0, 3'd0, 16'h0, 3'b000, 6'h00);
    idle(3'b000, 6'h2A);
    check("rst_out",    32'(s_out), 32'h2A);
    check("rst_active", 32'(s_active), 32'd0);
    check("rst_err",    32'(s_err), 32'd0);
    check("rst_state",  32'(s_state), 32'(IDLE));

    // 2: repeating trigger, HOLD=2 gives a 3-cycle override on bit 0
    cfg_basic(8'd2);
    wr(3'd0, 16'h0001);
    idle(3'b000, 6'h3F);            // IDLE->ARMED transition cycle
    idle(3'b110, 6'h3F);            // match sampled at the end of this cycle
    cnt_a = 0; cnt_o = 0;
    for (int i = 0; i < 6; i++) begin
      idle(3'b000, 6'h3F);
      if (s_active) cnt_a++;
      if (!s_out[0]) cnt_o++;
    end
    check("t2_active_cycles", 32'(cnt_a), 32'd3);
    check("t2_out0_low",      32'(cnt_o), 32'd3);
    wr(3'd0, 16'h0000);

    // 3: oneshot with a persistent match fires exactly once
    wr(3'd0, 16'h0003);
    idle(3'b110, 6'h3F);            // transition cycle: match ignored
    cnt_a = 0;
    for (int i = 0; i < 8; i++) begin
      idle(3'b110, 6'h3F);
      if (s_active) cnt_a++;
    end
    check("t3_active_cycles", 32'(cnt_a), 32'd3);
    check("t3_done",          32'(s_state), 32'(DONE));
    wr(3'd0, 16'h0000);
    idle(3'b000, 6'h3F);
    check("t3_idle",          32'(s_state), 32'(IDLE));

    // 4: locked writes and bad address both pulse cfg_err
    wr(3'd0, 16'h0001);
    cnt_e = 0;
    wr(3'd3, 16'h003E);
    if (s_err) cnt_e++;
    wr(3'd7, 16'h0000);
    if (s_err) cnt_e++;
    idle(3'b000, 6'h3F);
    if (s_err) cnt_e++;
    idle(3'b000, 6'h3F);
    if (s_err) cnt_e++;
    check("t4_err_pulses", 32'(cnt_e), 32'd2);
    idle(3'b110, 6'h3F);
    idle(3'b000, 6'h3F);
    check("t4_ovr_mask_kept", 32'(s_out), 32'h3E);
    wr(3'd0, 16'h0000);

    // 5: disable on the 3rd override cycle, then reset on the 3rd cycle
    wr(3'd5, 16'd10);
    wr(3'd0, 16'h0001);
    idle(3'b000, 6'h3F);
    idle(3'b110, 6'h3F);
    idle(3'b000, 6'h3F);
    idle(3'b000, 6'h3F);
    wr(3'd0, 16'h0000);             // 3rd override cycle
    check("t5_active_before", 32'(s_active), 32'd1);
    idle(3'b000, 6'h3F);
    check("t5_dis_active", 32'(s_active), 32'd0);
    check("t5_dis_state",  32'(s_state), 32'(IDLE));
    wr(3'd0, 16'h0001);
    idle(3'b000, 6'h3F);
    idle(3'b110, 6'h3F);
    idle(3'b000, 6'h3F);
    idle(3'b000, 6'h3F);
    cycle(1'b1, 1'b0, 3'd0, 16'h0, 3'b000, 6'h3F);
    idle(3'b000, 6'h15);
    check("t5_rst_active", 32'(s_active), 32'd0);
    check("t5_rst_out",    32'(s_out), 32'h15);
    // cleared registers: zero mask matches always, zero override mask
    wr(3'd0, 16'h0001);
    for (int i = 0; i < 6; i++) idle(3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, v;
      logic [2:0] a;
      r  = ($urandom_range(0, 299) == 0);
      v  = ($urandom_range(0, 5) == 0);
      a  = 3'($urandom_range(0, 7));
      rd = 16'($urandom_range(0, 65535));
      if (a == 3'd0) rd[0] = ($urandom_range(0, 3) != 0);
      cycle(r, v, a, rd, 3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)));
    end

`ifdef PATCH_EVENT_CNT_EN
    // 6: back-to-back triggers saturate the event counter
    cycle(1'b1, 1'b0, 3'd0, 16'h0, 3'b000, 6'h00);
    wr(3'd0, 16'h0001);
    for (int i = 0; i < 600; i++) idle(3'($urandom_range(0, 7)), 6'h00);
    idle(3'b000, 6'h00);
    check("t6_saturate", 32'(event_count), 32'hFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
